// File: rtl/counter_pkg.sv
// Shared definitions for the parametrised counter and the blocks that reuse it.
//   CNT_WRAP / CNT_SAT : terminal behaviour (SATURATE parameter values)
//   DIR_UP / DIR_DN    : up_dn input encoding
//   clamp_to_max       : limits a value to a terminal value, widths up to 32 bits
package counter_pkg;
  localparam bit CNT_WRAP  = 1'b0;
  localparam bit CNT_SAT   = 1'b1;
  localparam bit DIR_UP    = 1'b1;
  localparam bit DIR_DN    = 1'b0;
  localparam int CNT_MAX_W = 32;

  // One extra bit so callers can compare any WIDTH <= 32 value without sign or wrap issues.
  function automatic logic [CNT_MAX_W:0] clamp_to_max(input logic [CNT_MAX_W:0] value,
                                                      input logic [CNT_MAX_W:0] max_v);
    return (value > max_v) ? max_v : value;
  endfunction
endpackage

// File: rtl/prescaler_tick.sv
// Enable prescaler: emits one step every PRESCALE enabled cycles.
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset, phase -> 0
//   enable  : phase advances only while high
//   clear   : synchronous phase clear (wins over enable)
//   step    : enable && (phase == PRESCALE-1), combinational
module prescaler_tick #(
  parameter int PRESCALE = 1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic enable,
  input  logic clear,
  output logic step
);
  // PRESCALE = 1 keeps a 1-bit phase pinned at 0, so step collapses to enable.
  localparam int            PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] r_phase;
  logic          w_last;

  assign w_last = (r_phase == LAST);
  assign step   = enable && w_last;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)    r_phase <= '0;
    else if (clear)  r_phase <= '0;
    else if (enable) r_phase <= w_last ? '0 : r_phase + PW'(1);
  end
endmodule

// File: rtl/mod_counter_param.sv
// Parametrised event/timebase counter: up/down, synchronous load, wrap or
// saturate at the terminal, prescaled enable, tc pulse and sticky overflow.
//   clock, reset_n : rising-edge clock, asynchronous active-low reset
//   enable, up_dn  : count enable, direction (1 = up)
//   load, load_val : synchronous load (clamped to MAX_VAL), highest priority
//   ovf_clr        : clears overflow unless a terminal event hits the same edge
//   counter_out    : registered count, 0..MAX_VAL
//   tc             : one-cycle pulse after each terminal event
//   overflow       : sticky terminal-event flag
module mod_counter_param
  import counter_pkg::*;
#(
  parameter int               WIDTH    = 12,
  parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
  parameter bit               SATURATE = CNT_WRAP,
  parameter int               PRESCALE = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] counter_out,
  output logic             tc,
  output logic             overflow
);
  logic [WIDTH-1:0] r_cnt;
  logic             r_tc;
  logic             r_ovf;

  logic             w_step;
  logic             w_at_top;
  logic             w_at_bot;
  logic             w_term;
  logic [WIDTH:0]   w_cnt_ext;
  logic [WIDTH-1:0] w_load_val;
  logic [WIDTH-1:0] w_next;

  // Load also clears the prescaler so the next step is a full PRESCALE away.
  prescaler_tick #(.PRESCALE(PRESCALE)) u_prescaler (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  (enable),
    .clear   (load),
    .step    (w_step)
  );

  assign w_cnt_ext  = {1'b0, r_cnt};
  assign w_at_top   = (r_cnt == MAX_VAL);
  assign w_at_bot   = (r_cnt == '0);
  assign w_load_val = WIDTH'(clamp_to_max((CNT_MAX_W+1)'(load_val), (CNT_MAX_W+1)'(MAX_VAL)));
  // A load on the same edge suppresses the terminal event entirely.
  assign w_term     = w_step && !load && ((up_dn == DIR_UP) ? w_at_top : w_at_bot);

  // +/-1 is only taken strictly inside 0..MAX_VAL, so the truncation never drops a carry.
  always_comb begin
    w_next = r_cnt;
    if (load) begin
      w_next = w_load_val;
    end else if (w_step) begin
      if (up_dn == DIR_UP)
        w_next = w_at_top ? ((SATURATE == CNT_SAT) ? MAX_VAL : '0)
                          : WIDTH'(w_cnt_ext + (WIDTH+1)'(1));
      else
        w_next = w_at_bot ? ((SATURATE == CNT_SAT) ? '0 : MAX_VAL)
                          : WIDTH'(w_cnt_ext - (WIDTH+1)'(1));
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_tc  <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      r_cnt <= w_next;
      r_tc  <= w_term;
      if (w_term)       r_ovf <= 1'b1;
      else if (ovf_clr) r_ovf <= 1'b0;
    end
  end

  assign counter_out = r_cnt;
  assign tc          = r_tc;
  assign overflow    = r_ovf;
endmodule

// File: tb/tb_mod_counter_param.sv
module tb_mod_counter_param;
  typedef struct packed {
    logic       en;
    logic       ud;
    logic       ld;
    logic       clr;
    logic [3:0] lv;
  } ctl4_t;

  logic        clock;
  logic        reset_n;

  // default-parameter instance
  logic        d_en, d_ud, d_ld, d_clr;
  logic [11:0] d_lv, d_cnt;
  logic        d_tc, d_ovf;

  // 4-bit MAX_VAL=9 instances: 0 wrap, 1 saturate, 2 prescale 3
  ctl4_t       c [3];
  logic [3:0]  q_cnt [3];
  logic        q_tc  [3];
  logic        q_ovf [3];

  int n_chk  = 0;
  int n_pass = 0;
  int tc_cnt = 0;
  int pre_en  [7] = '{1, 1, 0, 1, 1, 1, 1};
  int pre_exp [7] = '{0, 0, 0, 1, 1, 1, 2};

  mod_counter_param u_def (
    .clock(clock), .reset_n(reset_n), .enable(d_en), .up_dn(d_ud), .load(d_ld),
    .load_val(d_lv), .ovf_clr(d_clr), .counter_out(d_cnt), .tc(d_tc), .overflow(d_ovf)
  );

  mod_counter_param #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b0), .PRESCALE(1)) u_wrap (
    .clock(clock), .reset_n(reset_n), .enable(c[0].en), .up_dn(c[0].ud), .load(c[0].ld),
    .load_val(c[0].lv), .ovf_clr(c[0].clr), .counter_out(q_cnt[0]), .tc(q_tc[0]), .overflow(q_ovf[0])
  );

  mod_counter_param #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b1), .PRESCALE(1)) u_sat (
    .clock(clock), .reset_n(reset_n), .enable(c[1].en), .up_dn(c[1].ud), .load(c[1].ld),
    .load_val(c[1].lv), .ovf_clr(c[1].clr), .counter_out(q_cnt[1]), .tc(q_tc[1]), .overflow(q_ovf[1])
  );

  mod_counter_param #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b0), .PRESCALE(3)) u_pre (
    .clock(clock), .reset_n(reset_n), .enable(c[2].en), .up_dn(c[2].ud), .load(c[2].ld),
    .load_val(c[2].lv), .ovf_clr(c[2].clr), .counter_out(q_cnt[2]), .tc(q_tc[2]), .overflow(q_ovf[2])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // inputs change and outputs are sampled 1ns after the rising edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    d_en = 1'b0; d_ud = 1'b1; d_ld = 1'b0; d_clr = 1'b0; d_lv = '0;
    for (int i = 0; i < 3; i++) begin
      c[i]    = '0;
      c[i].ud = 1'b1;
    end
    tick(); tick();

    chk("rst_def_cnt", 32'(d_cnt), 0);
    chk("rst_def_tc",  32'(d_tc),  0);
    chk("rst_def_ovf", 32'(d_ovf), 0);
    for (int i = 0; i < 3; i++) chk($sformatf("rst_cnt%0d", i), 32'(q_cnt[i]), 0);
    reset_n = 1'b1;

    // default WIDTH=12: 4096 up steps return to 0 with a single tc pulse
    d_en = 1'b1;
    for (int i = 1; i <= 4096; i++) begin
      tick();
      if (d_tc) tc_cnt++;
      if (i == 4095) chk("def_top", 32'(d_cnt), 32'h0FFF);
    end
    chk("def_wrap_cnt",  32'(d_cnt), 0);
    chk("def_tc_pulses", 32'(tc_cnt), 1);
    chk("def_ovf",       32'(d_ovf), 1);
    d_en = 1'b0;
    tick();
    chk("def_tc_low", 32'(d_tc),  0);
    chk("def_hold",   32'(d_cnt), 0);

    // reach 0x5A3, then reset asynchronously between edges
    d_ld = 1'b1; d_lv = 12'h5A2;
    tick();
    d_ld = 1'b0;
    chk("def_load",     32'(d_cnt), 32'h5A2);
    chk("def_load_ovf", 32'(d_ovf), 1);
    d_en = 1'b1;
    tick();
    d_en = 1'b0;
    chk("def_5a3", 32'(d_cnt), 32'h5A3);
    #3 reset_n = 1'b0;
    #1;
    chk("async_cnt", 32'(d_cnt), 0);
    chk("async_tc",  32'(d_tc),  0);
    chk("async_ovf", 32'(d_ovf), 0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("rel_noen", 32'(d_cnt), 0);
    d_en = 1'b1;
    tick();
    d_en = 1'b0;
    chk("rel_step", 32'(d_cnt), 1);

    // wrap up, MAX_VAL=9: 1..9,0,1
    c[0].en = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      tick();
      chk($sformatf("wrap_cnt%0d", i), 32'(q_cnt[0]), 32'(i % 10));
      chk($sformatf("wrap_tc%0d",  i), 32'(q_tc[0]),  32'(i == 10));
      chk($sformatf("wrap_ovf%0d", i), 32'(q_ovf[0]), 32'(i >= 10));
    end

    // load 15 clamps to 9 and beats the coincident step; next step wraps with tc
    c[0].ld = 1'b1; c[0].lv = 4'd15;
    tick();
    c[0].ld = 1'b0;
    chk("ldpri_cnt", 32'(q_cnt[0]), 9);
    chk("ldpri_tc",  32'(q_tc[0]),  0);
    tick();
    chk("ldpri_wrap_cnt", 32'(q_cnt[0]), 0);
    chk("ldpri_wrap_tc",  32'(q_tc[0]),  1);
    c[0].en = 1'b0;
    tick();
    chk("ldpri_tc_low", 32'(q_tc[0]), 0);

    // saturate down from 2
    c[1].ud = 1'b0; c[1].ld = 1'b1; c[1].lv = 4'd2;
    tick();
    c[1].ld = 1'b0;
    chk("sat_load", 32'(q_cnt[1]), 2);
    chk("sat_ovf0", 32'(q_ovf[1]), 0);
    c[1].en = 1'b1;
    tick();
    chk("sat_cnt1", 32'(q_cnt[1]), 1);
    chk("sat_tc1",  32'(q_tc[1]),  0);
    tick();
    chk("sat_cnt0", 32'(q_cnt[1]), 0);
    chk("sat_tc0",  32'(q_tc[1]),  0);
    c[1].clr = 1'b1;
    tick();
    chk("sat_hold_a", 32'(q_cnt[1]), 0);
    chk("sat_tc_a",   32'(q_tc[1]),  1);
    chk("sat_ovf_clr_term", 32'(q_ovf[1]), 1);
    c[1].clr = 1'b0;
    tick();
    chk("sat_hold_b", 32'(q_cnt[1]), 0);
    chk("sat_tc_b",   32'(q_tc[1]),  1);
    c[1].en = 1'b0; c[1].clr = 1'b1;
    tick();
    c[1].clr = 1'b0;
    chk("sat_clr_cnt", 32'(q_cnt[1]), 0);
    chk("sat_clr_tc",  32'(q_tc[1]),  0);
    chk("sat_clr_ovf", 32'(q_ovf[1]), 0);
    // saturate up: 8 -> 9 -> 9 (tc)
    c[1].ud = 1'b1; c[1].ld = 1'b1; c[1].lv = 4'd8;
    tick();
    c[1].ld = 1'b0; c[1].en = 1'b1;
    tick();
    chk("satup_cnt9", 32'(q_cnt[1]), 9);
    chk("satup_tc0",  32'(q_tc[1]),  0);
    tick();
    chk("satup_hold", 32'(q_cnt[1]), 9);
    chk("satup_tc1",  32'(q_tc[1]),  1);
    chk("satup_ovf",  32'(q_ovf[1]), 1);
    c[1].en = 1'b0;

    // prescale 3 with enable pattern 1,1,0,1,1,1,1
    for (int i = 0; i < 7; i++) begin
      c[2].en = pre_en[i][0];
      tick();
      chk($sformatf("pre_cnt%0d", i), 32'(q_cnt[2]), 32'(pre_exp[i]));
    end
    tick();                              // phase 0 -> 1, no step
    chk("pre_mid", 32'(q_cnt[2]), 2);
    c[2].ld = 1'b1; c[2].lv = 4'd15;     // load clears the phase
    tick();
    c[2].ld = 1'b0;
    chk("pre_load", 32'(q_cnt[2]), 9);
    tick();
    chk("pre_ph1", 32'(q_cnt[2]), 9);
    tick();
    chk("pre_ph2", 32'(q_cnt[2]), 9);
    tick();
    chk("pre_wrap_cnt", 32'(q_cnt[2]), 0);
    chk("pre_wrap_tc",  32'(q_tc[2]),  1);
    // direction flips mid-prescale without disturbing the phase
    tick();
    c[2].ud = 1'b0;
    tick();
    chk("pre_dir_hold", 32'(q_cnt[2]), 0);
    tick();
    chk("pre_dir_cnt", 32'(q_cnt[2]), 9);
    chk("pre_dir_tc",  32'(q_tc[2]),  1);
    c[2].en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
